uart_frame_loader: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its byte strobe and byte.
- Hunts a 2-byte sync header, collects one 28x28 MNIST image (PIX_NUM bytes), and writes each byte into the image buffer RAM through a simple write port.
- Signals the inference core with frame_done once a complete, valid frame has been stored.
- Rejects malformed, stalled or ill-timed frames with frame_err and an error code.

---
 rtl/uart_frame_loader_if.sv | 27 ++
 rtl/uart_frame_loader.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_if.sv
// Byte stream from the UART receiver and the image RAM write port, bundled for the frame loader.
// The loader uses the master view; whatever feeds bytes and captures writes uses the slave view.
interface uart_frame_loader_if #(
   parameter int ADDR_W = 10
);
   logic              rx_done;
   logic [7:0]        rx_byte;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      input  rx_done,
      input  rx_byte,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output rx_done,
      output rx_byte,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/uart_frame_loader.sv
// Hunts an HDR0/HDR1 sync pair, stores one PIX_NUM-byte image into RAM and flags done/error.
// Optional LOADER_CHKSUM_EN adds a trailing mod-256 checksum byte verified in a CHK state.
module uart_frame_loader #(
   parameter int         PIX_NUM     = 784,
   parameter int         ADDR_W      = 10,
   parameter logic [7:0] HDR0        = 8'hAA,
   parameter logic [7:0] HDR1        = 8'h55,
   parameter int         TIMEOUT_CYC = 500000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   uart_frame_loader_if.master   bus,
   input  logic                  infer_busy,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_NUM - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_BUSY = 2'b11;

`ifdef LOADER_CHKSUM_EN
   localparam logic [1:0] ERR_CHK  = 2'b10;
   typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, HDR, DATA, DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              busy_q, busy_d;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         pix_q        <= '0;
         tmo_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
         busy_q       <= 1'b0;
`ifdef LOADER_CHKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pix_q        <= pix_d;
         tmo_q        <= tmo_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         busy_q       <= busy_d;
`ifdef LOADER_CHKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      pix_d        = pix_q;
      tmo_d        = '0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;
`ifdef LOADER_CHKSUM_EN
      sum_d        = sum_q;
`endif

      // Inter-byte watchdog; a byte arriving on the limit cycle takes priority
      if ((state_q == HDR) || (state_q == DATA)
`ifdef LOADER_CHKSUM_EN
          || (state_q == CHK)
`endif
         ) begin
         if (bus.rx_done) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.rx_done && (bus.rx_byte == HDR0)) state_d = HDR;
         end
         HDR: begin
            if (bus.rx_done) begin
               if (bus.rx_byte == HDR1) begin
                  if (infer_busy) begin
                     state_d     = IDLE;
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_BUSY;
                  end else begin
                     state_d = DATA;
                     pix_d   = '0;
`ifdef LOADER_CHKSUM_EN
                     sum_d   = '0;
`endif
                  end
               end else if (bus.rx_byte != HDR0) begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (bus.rx_done) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = pix_q;
               mem_wdata_d = bus.rx_byte;
`ifdef LOADER_CHKSUM_EN
               sum_d       = sum_q + bus.rx_byte;
`endif
               if (pix_q == LAST_PIX) begin
`ifdef LOADER_CHKSUM_EN
                  state_d = CHK;
`else
                  state_d = DONE;
`endif
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
         end
`ifdef LOADER_CHKSUM_EN
         // Done is flagged straight from the checksum byte so it lands one cycle after it
         CHK: begin
            if (bus.rx_done) begin
               if (bus.rx_byte == sum_q) begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
                  err_code_d   = ERR_NONE;
               end else begin
                  state_d     = IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
            end
         end
`endif
         DONE: begin
`ifndef LOADER_CHKSUM_EN
            frame_done_d = 1'b1;
            err_code_d   = ERR_NONE;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign frame_done    = frame_done_q;
   assign frame_err     = frame_err_q;
   assign err_code      = err_code_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed-sequence bench for uart_frame_loader with random pixel data and random byte gaps.
// Expected writes come from the frame image array; checksum is plain integer sum mod 256.
module tb_uart_frame_loader;

   localparam int PIX_NUM     = 784;
   localparam int ADDR_W      = 10;
   localparam int TIMEOUT_CYC = 1000;

   logic       sys_clk    = 1'b0;
   logic       sys_rst_n  = 1'b0;
   logic       infer_busy = 1'b0;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   uart_frame_loader_if #(.ADDR_W(ADDR_W)) lif();

   uart_frame_loader #(
      .PIX_NUM     (PIX_NUM),
      .ADDR_W      (ADDR_W),
      .HDR0        (8'hAA),
      .HDR1        (8'h55),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .bus        (lif),
      .infer_busy (infer_busy),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   err_cnt  = 0;
   int   done_cyc = 0;
   int   err_cyc  = 0;
   wr_t  wq[$];

   logic [7:0] img[PIX_NUM];
   int         pix_rx[PIX_NUM];
   int         last_rx;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Passive capture of RAM writes and status pulses, sampled mid-cycle
   always @(negedge sys_clk) begin
      if (lif.mem_we === 1'b1) wq.push_back('{int'(lif.mem_addr), int'(lif.mem_wdata), cyc});
      if (frame_done === 1'b1) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (frame_err === 1'b1) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] b, output int rx_cyc);
      @(negedge sys_clk);
      lif.rx_done = 1'b1;
      lif.rx_byte = b;
      rx_cyc      = cyc + 1;
      @(negedge sys_clk);
      lif.rx_done = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unused_cyc;
      apply_stimulus(b, unused_cyc);
      last_rx = unused_cyc;
   endtask

   task automatic send_pixels(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(img[i], pix_rx[i]);
      last_rx = pix_rx[n-1];
   endtask

   task automatic fill_image(input bit use_index);
      for (int i = 0; i < PIX_NUM; i++)
         img[i] = use_index ? 8'(i % 256) : 8'($urandom_range(0, 255));
   endtask

   function automatic logic [7:0] img_sum();
      int s = 0;
      for (int i = 0; i < PIX_NUM; i++) s += int'(img[i]);
      return 8'(s % 256);
   endfunction

   // Compares the captured writes against the first n image bytes, then clears the capture
   task automatic check_writes(input string tag, input int n);
      int bad_addr = 0;
      int bad_data = 0;
      int bad_lat  = 0;
      repeat (6) @(negedge sys_clk);
      check_output({tag, "_wr_count"}, wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++) begin
         if (wq[i].addr != i)         bad_addr++;
         if (wq[i].data != img[i])    bad_data++;
         if (wq[i].cyc  != pix_rx[i]) bad_lat++;
      end
      check_output({tag, "_addr_errs"}, bad_addr, 0);
      check_output({tag, "_data_errs"}, bad_data, 0);
      check_output({tag, "_latency_errs"}, bad_lat, 0);
      wq.delete();
   endtask

   task automatic send_good_frame();
      send_pixels(PIX_NUM);
`ifdef LOADER_CHKSUM_EN
      send_byte(img_sum());
`endif
   endtask

   task automatic check_good_frame(input string tag, input int d0, input int e0);
      int exp_done_cyc;
`ifdef LOADER_CHKSUM_EN
      exp_done_cyc = last_rx;
`else
      exp_done_cyc = pix_rx[PIX_NUM-1] + 1;
`endif
      check_writes(tag, PIX_NUM);
      check_output({tag, "_done_pulses"}, done_cnt - d0, 1);
      check_output({tag, "_err_pulses"}, err_cnt - e0, 0);
      check_output({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
      check_output({tag, "_err_code"}, err_code, 2'b00);
      check_output({tag, "_busy_idle"}, busy, 1'b0);
   endtask

   initial begin
      int d0;
      int e0;
      int gap;

      lif.rx_done = 1'b0;
      lif.rx_byte = 8'h00;

      // Reset values
      repeat (3) @(negedge sys_clk);
      check_output("rst_mem_we", lif.mem_we, 1'b0);
      check_output("rst_mem_addr", lif.mem_addr, '0);
      check_output("rst_mem_wdata", lif.mem_wdata, 8'h00);
      check_output("rst_frame_done", frame_done, 1'b0);
      check_output("rst_frame_err", frame_err, 1'b0);
      check_output("rst_err_code", err_code, 2'b00);
      check_output("rst_busy", busy, 1'b0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // Index-pattern frame
      $display("[TB] index pattern frame");
      fill_image(1'b1);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_good_frame();
      check_good_frame("idx", d0, e0);

      // Junk byte and repeated HDR0 before the sync pair
      $display("[TB] junk and repeated header");
      fill_image(1'b0);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h12);
      send_byte(8'hAA);
      send_byte(8'hAA);
      send_byte(8'h55);
      send_good_frame();
      check_good_frame("junk", d0, e0);

      // Stall mid-frame
      $display("[TB] timeout after 100 pixels");
      fill_image(1'b0);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_pixels(100);
      for (int k = 0; k < 3 * TIMEOUT_CYC && err_cnt == e0; k++) @(negedge sys_clk);
      check_writes("tmo", 100);
      check_output("tmo_err_pulses", err_cnt - e0, 1);
      check_output("tmo_err_code", err_code, 2'b01);
      check_output("tmo_busy", busy, 1'b0);
      check_output("tmo_no_done", done_cnt - d0, 0);
      gap = err_cyc - pix_rx[99];
      check_output("tmo_window", (gap >= TIMEOUT_CYC) && (gap <= TIMEOUT_CYC + 1), 1'b1);
      fill_image(1'b0);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_good_frame();
      check_good_frame("post_tmo", d0, e0);

`ifdef LOADER_CHKSUM_EN
      $display("[TB] bad checksum");
      fill_image(1'b0);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_pixels(PIX_NUM);
      send_byte(img_sum() + 8'h01);
      check_writes("badchk", PIX_NUM);
      check_output("badchk_err_pulses", err_cnt - e0, 1);
      check_output("badchk_err_code", err_code, 2'b10);
      check_output("badchk_no_done", done_cnt - d0, 0);
`endif

      // Consumer still busy at the sync pair
      $display("[TB] inference busy drop");
      d0 = done_cnt; e0 = err_cnt;
      infer_busy = 1'b1;
      send_byte(8'hAA);
      send_byte(8'h55);
      infer_busy = 1'b0;
      check_writes("bdrop", 0);
      check_output("bdrop_err_pulses", err_cnt - e0, 1);
      check_output("bdrop_err_code", err_code, 2'b11);
      check_output("bdrop_busy", busy, 1'b0);
      check_output("bdrop_no_done", done_cnt - d0, 0);
      fill_image(1'b0);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_good_frame();
      check_good_frame("retry", d0, e0);

      // Reset in the middle of a frame
      $display("[TB] reset at pixel 400");
      fill_image(1'b0);
      e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_pixels(400);
      sys_rst_n = 1'b0;
      #1;
      check_output("mrst_mem_we", lif.mem_we, 1'b0);
      check_output("mrst_mem_addr", lif.mem_addr, '0);
      check_output("mrst_mem_wdata", lif.mem_wdata, 8'h00);
      check_output("mrst_frame_done", frame_done, 1'b0);
      check_output("mrst_frame_err", frame_err, 1'b0);
      check_output("mrst_err_code", err_code, 2'b00);
      check_output("mrst_busy", busy, 1'b0);
      repeat (3) @(negedge sys_clk);
      wq.delete();
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      check_output("mrst_no_err", err_cnt - e0, 0);
      fill_image(1'b0);
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_good_frame();
      check_good_frame("post_rst", d0, e0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
